// File: rtl/debounce_filter_mc.sv
// NCH-channel debounce filter. Each channel has a two-flop synchroniser and a
// tick-driven saturating integrator with hysteresis. It outputs a registered level plus rise/fall pulses.
module debounce_filter_mc #(
  parameter int NCH   = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       i_tick,
  input  logic [2*NCH-1:0] cfg_tick_sel,
  input  logic [NCH-1:0]   cfg_bypass,
  input  logic [NCH-1:0]   in_raw,
  output logic [NCH-1:0]   db_out,
  output logic [NCH-1:0]   rise_pulse,
  output logic [NCH-1:0]   fall_pulse,
  output logic             any_event
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Move one step toward the sampled level, clamping at 0 and MAX.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                input logic up);
    if (up) return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    else    return (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
  endfunction

  logic [NCH-1:0]   s1_q, s2_q;
  logic [NCH-1:0]   filt_q, filt_d;
  logic [NCH-1:0]   db_q, db_d;
  logic [NCH-1:0]   rise_q, rise_d;
  logic [NCH-1:0]   fall_q, fall_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_tick[cfg_tick_sel[2*i +: 2]]) begin
        cnt_d[i] = sat_step(cnt_q[i], s2_q[i]);
      end
      // Between the rails the filter holds its last decision.
      if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = 1'b1;
      end else if (cnt_q[i] == CNT_ZERO) begin
        filt_d[i] = 1'b0;
      end
    end
  end

  assign db_d   = (cfg_bypass & s2_q) | (~cfg_bypass & filt_q);
  assign rise_d = db_d & ~db_q;
  assign fall_d = ~db_d & db_q;
  assign any_d  = |(rise_q | fall_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= in_raw;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_event  = any_q;

endmodule
